mycpu_io: RTL

Memory-mapped I/O responder on the processor's I/O bus; it serves the I/O-space transactions the CPU initiates. It decodes I/O-space writes and reads and hosts three peripherals: a general-purpose output register, a synchronized general-purpose input with rising-edge capture, and a 16-bit down-counting timer. It sits beside the CPU top level:
- CPU address, write data, write enable and I/O select feed this block.
- `io_out` drives the CPU's I/O read-data input.

---
 rtl/mycpu_io_if.sv | 24 ++
 rtl/mycpu_io.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mycpu_io_if.sv
// CPU-side I/O bus bundle: address, write data, strobes and read-data return.
interface mycpu_io_if;
  logic [15:0] a_in;
  logic [15:0] d_in;
  logic        wen_in;
  logic        iom_in;
  logic [15:0] io_out;

  modport master (
    output a_in,
    output d_in,
    output wen_in,
    output iom_in,
    input  io_out
  );

  modport slave (
    input  a_in,
    input  d_in,
    input  wen_in,
    input  iom_in,
    output io_out
  );
endinterface

// File: rtl/mycpu_io.sv
// Memory-mapped I/O responder: GPO register, synchronized GPI with sticky
// rising-edge flags, and a 16-bit down-counting timer with optional reload.
module mycpu_io (
  input  logic        clk,
  input  logic        rst_n,
  mycpu_io_if.slave   bus,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        tick_out
);

  localparam logic [2:0] A_GPO    = 3'd0;
  localparam logic [2:0] A_GPI    = 3'd1;
  localparam logic [2:0] A_TCTRL  = 3'd2;
  localparam logic [2:0] A_TLOAD  = 3'd3;
  localparam logic [2:0] A_TCOUNT = 3'd4;
  localparam logic [2:0] A_STAT   = 3'd5;
  localparam logic [2:0] A_EDGE   = 3'd6;

  logic [2:0]  idx;
  logic        wr_en;
  logic        rd_en;
  logic        expire;

  logic [15:0] gpo_q, gpo_d;
  logic        en_q, en_d;
  logic        ar_q, ar_d;
  logic [15:0] tload_q, tload_d;
  logic [15:0] tcount_q, tcount_d;
  logic        exp_q, exp_d;
  logic [15:0] edge_q, edge_d;
  logic [15:0] s1_q, s2_q, s3_q;
  logic        tick_q;

  // Upper address bits are don't-care: the map aliases every 8 words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.a_in[15:3];

  assign idx    = bus.a_in[2:0];
  assign wr_en  = bus.iom_in & bus.wen_in;
  assign rd_en  = bus.iom_in & ~bus.wen_in;
  // Terminal count while enabled is the expiry event for this edge.
  assign expire = en_q & (tcount_q == 16'd0);

  // Next state: timer step first, then bus writes override, then hardware sets win over W1C.
  always_comb begin
    gpo_d    = gpo_q;
    en_d     = en_q;
    ar_d     = ar_q;
    tload_d  = tload_q;
    tcount_d = tcount_q;
    exp_d    = exp_q;
    edge_d   = edge_q;

    if (en_q) begin
      if (tcount_q != 16'd0) begin
        tcount_d = tcount_q - 16'd1;
      end else if (ar_q) begin
        tcount_d = tload_q;
      end else begin
        en_d = 1'b0;
      end
    end

    if (wr_en) begin
      case (idx)
        A_GPO:   gpo_d = bus.d_in;
        A_TCTRL: begin
          en_d = bus.d_in[0];
          ar_d = bus.d_in[1];
        end
        A_TLOAD: begin
          tload_d  = bus.d_in;
          tcount_d = bus.d_in;
        end
        A_STAT:  if (bus.d_in[0]) exp_d = 1'b0;
        A_EDGE:  edge_d = edge_q & ~bus.d_in;
        default: ;
      endcase
    end

    if (expire) exp_d = 1'b1;
    edge_d = edge_d | (s2_q & ~s3_q);
  end

  // State registers, including the three-flop input synchronizer and tick pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpo_q    <= '0;
      en_q     <= 1'b0;
      ar_q     <= 1'b0;
      tload_q  <= '0;
      tcount_q <= '0;
      exp_q    <= 1'b0;
      edge_q   <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      tick_q   <= 1'b0;
    end else begin
      gpo_q    <= gpo_d;
      en_q     <= en_d;
      ar_q     <= ar_d;
      tload_q  <= tload_d;
      tcount_q <= tcount_d;
      exp_q    <= exp_d;
      edge_q   <= edge_d;
      s1_q     <= sw_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      tick_q   <= expire;
    end
  end

  // Combinational read mux; forced to zero outside I/O reads and during reset.
  always_comb begin
    bus.io_out = 16'h0000;
    if (rst_n && rd_en) begin
      case (idx)
        A_GPO:    bus.io_out = gpo_q;
        A_GPI:    bus.io_out = s2_q;
        A_TCTRL:  bus.io_out = {14'd0, ar_q, en_q};
        A_TLOAD:  bus.io_out = tload_q;
        A_TCOUNT: bus.io_out = tcount_q;
        A_STAT:   bus.io_out = {15'd0, exp_q};
        A_EDGE:   bus.io_out = edge_q;
        default:  bus.io_out = 16'h0000;
      endcase
    end
  end

  assign led_out  = gpo_q;
  assign tick_out = tick_q;

endmodule
